// File: rtl/branch_flush_controller_pkg.sv
// Shared types and constants for the branch flush controller.
// Branch-type encodings, sizes, BHT init value and FSM states.
package branch_flush_controller_pkg;

    localparam int PC_W      = 10;
    localparam int BHT_IDX_W = 4;
    localparam int BHT_DEPTH = 16;
    localparam int CNT_W     = 16;

    localparam logic [1:0] BHT_INIT = 2'b01;

    typedef enum logic [3:0] {
        BR_NONE  = 4'd0,
        BR_BRCC  = 4'd1,
        BR_BRCS  = 4'd2,
        BR_BREQ  = 4'd3,
        BR_BRN   = 4'd4,
        BR_BRNE  = 4'd5,
        BR_CALL  = 4'd6,
        BR_RET   = 4'd7,
        BR_RETID = 4'd8,
        BR_RETIE = 4'd9
    } br_type_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    function automatic logic br_resolves(input logic [3:0] t);
        return (t >= BR_BRCC) && (t <= BR_RETIE);
    endfunction

    // Only conditional branches train the predictor.
    function automatic logic br_is_cond(input logic [3:0] t);
        return (t >= BR_BRCC) && (t <= BR_BRNE);
    endfunction

endpackage

// File: rtl/branch_flush_controller_bht.sv
// 16-entry table of 2-bit saturating taken counters.
// Async read for fetch, sync update from EX resolution.
module branch_history_table
    import branch_flush_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BHT_IDX_W-1:0] rd_idx,
    output logic [1:0]           rd_ctr,
    input  logic                 upd_en,
    input  logic [BHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_taken
);

    logic [1:0] ctr_q [BHT_DEPTH];

    assign rd_ctr = ctr_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i] <= BHT_INIT;
            end
        end else if (upd_en) begin
            if (upd_taken && ctr_q[upd_idx] != 2'b11) begin
                ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
            end else if (!upd_taken && ctr_q[upd_idx] != 2'b00) begin
                ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_flush_controller.sv
// Resolves EX branches, sequences redirect/flush on mispredict,
// trains the BHT and counts mispredicts.
module branch_flush_controller
    import branch_flush_controller_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] IF_PC,
    input  logic            IF_IS_BRANCH,
    output logic            PREDICT_TAKEN,
    input  logic            EX_VALID,
    input  logic [PC_W-1:0] EX_PC,
    input  logic [3:0]      EX_BRANCH_TYPE,
    input  logic            EX_BRANCH_TAKEN,
    input  logic            EX_BRANCH_MISS,
    input  logic [PC_W-1:0] EX_TARGET,
    input  logic            STALL,
    output logic            PC_REDIRECT,
    output logic [PC_W-1:0] PC_REDIRECT_ADDR,
    output logic            FLUSH_IF,
    output logic            FLUSH_ID,
    output logic            FLUSH_EX,
    output logic [CNT_W-1:0] MISS_COUNT
);

    state_e           state_q;
    state_e           state_d;
    logic [PC_W-1:0]  redirect_addr_q;
    logic [CNT_W-1:0] miss_count_q;
    logic [PC_W-1:0]  fall_thru;
    logic             accept_res;
    logic             accept_miss;
    logic             bht_upd;
    logic [1:0]       if_ctr;
    logic             unused_pc_bits;

    // While redirecting, EX holds a wrong-path instruction.
    assign accept_res  = EX_VALID & ~STALL & (state_q == ST_IDLE)
                       & br_resolves(EX_BRANCH_TYPE);
    assign accept_miss = accept_res & EX_BRANCH_MISS;
    assign bht_upd     = accept_res & br_is_cond(EX_BRANCH_TYPE);
    assign fall_thru   = EX_PC + 10'd1;

    assign unused_pc_bits = ^{IF_PC[PC_W-1:BHT_IDX_W],
                              EX_PC[PC_W-1:BHT_IDX_W]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (accept_miss) state_d = ST_REDIRECT;
            ST_REDIRECT: if (!STALL) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            redirect_addr_q <= '0;
        end else if (accept_miss) begin
            redirect_addr_q <= EX_BRANCH_TAKEN ? EX_TARGET : fall_thru;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            miss_count_q <= '0;
        end else if (accept_miss && miss_count_q != '1) begin
            miss_count_q <= miss_count_q + 16'd1;
        end
    end

    branch_history_table u_bht (
        .clk       (CLK),
        .rst       (RST),
        .rd_idx    (IF_PC[BHT_IDX_W-1:0]),
        .rd_ctr    (if_ctr),
        .upd_en    (bht_upd),
        .upd_idx   (EX_PC[BHT_IDX_W-1:0]),
        .upd_taken (EX_BRANCH_TAKEN)
    );

    assign PREDICT_TAKEN    = IF_IS_BRANCH & if_ctr[1];
    assign PC_REDIRECT      = (state_q == ST_REDIRECT);
    assign FLUSH_IF         = (state_q == ST_REDIRECT);
    assign FLUSH_ID         = (state_q == ST_REDIRECT);
    assign FLUSH_EX         = (state_q == ST_REDIRECT);
    assign PC_REDIRECT_ADDR = redirect_addr_q;
    assign MISS_COUNT       = miss_count_q;

endmodule

// File: tb/tb_branch_flush_controller.sv
// Bench for branch_flush_controller: directed vector table,
// random traffic against a reference model, corner sequences.
module tb_branch_flush_controller;

    typedef struct {
        logic       rst;
        logic [9:0] if_pc;
        logic       if_br;
        logic       ex_v;
        logic [9:0] ex_pc;
        logic [3:0] ty;
        logic       tk;
        logic       ms;
        logic [9:0] tgt;
        logic       st;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        e_red;
        logic [9:0]  e_addr;
        logic [15:0] e_cnt;
        logic        e_pred;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  if_pc;
    logic        if_br;
    logic        predict_taken;
    logic        ex_v;
    logic [9:0]  ex_pc;
    logic [3:0]  ex_ty;
    logic        ex_tk;
    logic        ex_ms;
    logic [9:0]  ex_tgt;
    logic        stall;
    logic        pc_redirect;
    logic [9:0]  pc_redirect_addr;
    logic        flush_if;
    logic        flush_id;
    logic        flush_ex;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    int m_bht [16];
    bit m_red;
    int m_addr;
    int m_cnt;

    vec_t tbl [24];

    always #5 clk = ~clk;

    branch_flush_controller dut (
        .CLK              (clk),
        .RST              (rst),
        .IF_PC            (if_pc),
        .IF_IS_BRANCH     (if_br),
        .PREDICT_TAKEN    (predict_taken),
        .EX_VALID         (ex_v),
        .EX_PC            (ex_pc),
        .EX_BRANCH_TYPE   (ex_ty),
        .EX_BRANCH_TAKEN  (ex_tk),
        .EX_BRANCH_MISS   (ex_ms),
        .EX_TARGET        (ex_tgt),
        .STALL            (stall),
        .PC_REDIRECT      (pc_redirect),
        .PC_REDIRECT_ADDR (pc_redirect_addr),
        .FLUSH_IF         (flush_if),
        .FLUSH_ID         (flush_id),
        .FLUSH_EX         (flush_ex),
        .MISS_COUNT       (miss_count)
    );

    function automatic stim_t mks(
        input logic r, input logic [9:0] ip, input logic ib,
        input logic v, input logic [9:0] ep, input logic [3:0] t,
        input logic k, input logic m, input logic [9:0] g,
        input logic st);
        stim_t s;
        s.rst = r; s.if_pc = ip; s.if_br = ib; s.ex_v = v;
        s.ex_pc = ep; s.ty = t; s.tk = k; s.ms = m;
        s.tgt = g; s.st = st;
        return s;
    endfunction

    function automatic vec_t mkv(
        input stim_t s, input logic er, input logic [9:0] ea,
        input logic [15:0] ec, input logic ep);
        vec_t v;
        v.s = s; v.e_red = er; v.e_addr = ea;
        v.e_cnt = ec; v.e_pred = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_red  = 1'b0;
        m_addr = 0;
        m_cnt  = 0;
    endtask

    // Behaviour of one rising edge, from the architectural rules.
    task automatic model_step(input stim_t s);
        int idx;
        idx = int'(s.ex_pc) % 16;
        if (s.rst) begin
            model_reset();
        end else if (m_red) begin
            if (!s.st) m_red = 1'b0;
        end else if (s.ex_v && !s.st && s.ty >= 1 && s.ty <= 9) begin
            if (s.ty <= 5) begin
                if (s.tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
                else      m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
            end
            if (s.ms) begin
                m_red  = 1'b1;
                m_addr = s.tk ? int'(s.tgt) : (int'(s.ex_pc) + 1) % 1024;
                m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end
        end
    endtask

    task automatic run_cycle(input stim_t s, input bit use_tbl,
                             input vec_t v);
        logic        e_pred;
        logic        e_red;
        logic [9:0]  e_addr;
        logic [15:0] e_cnt;
        rst = s.rst; if_pc = s.if_pc; if_br = s.if_br;
        ex_v = s.ex_v; ex_pc = s.ex_pc; ex_ty = s.ty;
        ex_tk = s.tk; ex_ms = s.ms; ex_tgt = s.tgt; stall = s.st;
        #1;
        e_pred = use_tbl ? v.e_pred
                         : (s.if_br && m_bht[int'(s.if_pc) % 16] >= 2);
        chk("predict_taken", {31'd0, predict_taken}, {31'd0, e_pred});
        @(posedge clk);
        model_step(s);
        #1;
        e_red  = use_tbl ? v.e_red  : m_red;
        e_addr = use_tbl ? v.e_addr : m_addr[9:0];
        e_cnt  = use_tbl ? v.e_cnt  : m_cnt[15:0];
        chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, e_red});
        chk("flush_if", {31'd0, flush_if}, {31'd0, e_red});
        chk("flush_id", {31'd0, flush_id}, {31'd0, e_red});
        chk("flush_ex", {31'd0, flush_ex}, {31'd0, e_red});
        chk("redirect_addr", {22'd0, pc_redirect_addr}, {22'd0, e_addr});
        chk("miss_count", {16'd0, miss_count}, {16'd0, e_cnt});
    endtask

    initial begin
        stim_t s;
        vec_t  nv;
        stim_t miss_s;

        nv = mkv(mks(0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0);

        tbl[0]  = mkv(mks(1,10'h005,1, 0,10'h000,4'd0,0,0,10'h000,0), 0,10'h000,16'd0,0);
        tbl[1]  = mkv(mks(0,10'h005,1, 0,10'h000,4'd0,0,0,10'h000,0), 0,10'h000,16'd0,0);
        tbl[2]  = mkv(mks(0,10'h002,1, 1,10'h012,4'd3,1,1,10'h040,0), 1,10'h040,16'd1,0);
        tbl[3]  = mkv(mks(0,10'h002,1, 0,10'h000,4'd0,0,0,10'h000,0), 0,10'h040,16'd1,1);
        tbl[4]  = mkv(mks(0,10'h002,0, 0,10'h000,4'd0,0,0,10'h000,0), 0,10'h040,16'd1,0);
        tbl[5]  = mkv(mks(0,10'h00F,1, 1,10'h3FF,4'd5,0,1,10'h055,0), 1,10'h000,16'd2,0);
        tbl[6]  = mkv(mks(0,10'h00F,1, 1,10'h3FF,4'd5,0,1,10'h055,0), 0,10'h000,16'd2,0);
        tbl[7]  = mkv(mks(0,10'h00F,1, 1,10'h3FF,4'd5,0,0,10'h055,0), 0,10'h000,16'd2,0);
        tbl[8]  = mkv(mks(0,10'h00F,1, 1,10'h01F,4'd5,1,0,10'h055,0), 0,10'h000,16'd2,0);
        tbl[9]  = mkv(mks(0,10'h00F,1, 1,10'h00F,4'd5,1,0,10'h055,0), 0,10'h000,16'd2,0);
        tbl[10] = mkv(mks(0,10'h00F,1, 0,10'h000,4'd0,0,0,10'h000,0), 0,10'h000,16'd2,1);
        tbl[11] = mkv(mks(0,10'h000,0, 1,10'h020,4'd3,1,1,10'h0AA,0), 1,10'h0AA,16'd3,0);
        tbl[12] = mkv(mks(0,10'h000,0, 1,10'h030,4'd1,1,1,10'h111,1), 1,10'h0AA,16'd3,0);
        tbl[13] = mkv(mks(0,10'h000,0, 1,10'h030,4'd1,1,1,10'h111,1), 1,10'h0AA,16'd3,0);
        tbl[14] = mkv(mks(0,10'h000,0, 1,10'h030,4'd1,1,1,10'h111,1), 1,10'h0AA,16'd3,0);
        tbl[15] = mkv(mks(0,10'h000,0, 1,10'h030,4'd1,1,1,10'h111,0), 0,10'h0AA,16'd3,0);
        tbl[16] = mkv(mks(0,10'h000,1, 1,10'h05E,4'd7,1,1,10'h123,1), 0,10'h0AA,16'd3,1);
        tbl[17] = mkv(mks(0,10'h000,1, 1,10'h05E,4'd7,1,1,10'h123,0), 1,10'h123,16'd4,1);
        tbl[18] = mkv(mks(0,10'h00E,1, 0,10'h000,4'd0,0,0,10'h000,0), 0,10'h123,16'd4,0);
        tbl[19] = mkv(mks(0,10'h000,0, 1,10'h100,4'd0,1,1,10'h200,0), 0,10'h123,16'd4,0);
        tbl[20] = mkv(mks(0,10'h000,0, 1,10'h100,4'hA,1,1,10'h200,0), 0,10'h123,16'd4,0);
        tbl[21] = mkv(mks(0,10'h000,0, 0,10'h100,4'd2,1,1,10'h200,0), 0,10'h123,16'd4,0);
        tbl[22] = mkv(mks(0,10'h00E,1, 1,10'h00E,4'd6,1,0,10'h200,0), 0,10'h123,16'd4,0);
        tbl[23] = mkv(mks(0,10'h00E,1, 0,10'h000,4'd0,0,0,10'h000,0), 0,10'h123,16'd4,0);

        rst = 1'b1; if_pc = '0; if_br = 1'b0; ex_v = 1'b0;
        ex_pc = '0; ex_ty = '0; ex_tk = 1'b0; ex_ms = 1'b0;
        ex_tgt = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        for (int i = 0; i < 24; i++) begin
            run_cycle(tbl[i].s, 1'b1, tbl[i]);
        end

        for (int i = 0; i < 600; i++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            s.if_pc = 10'($urandom_range(0, 1023));
            s.if_br = 1'($urandom_range(0, 1));
            s.ex_v  = ($urandom_range(0, 3) != 0);
            s.ex_pc = 10'($urandom_range(0, 1023));
            s.ty    = 4'($urandom_range(0, 15));
            s.tk    = 1'($urandom_range(0, 1));
            s.ms    = ($urandom_range(0, 2) == 0);
            s.tgt   = 10'($urandom_range(0, 1023));
            s.st    = ($urandom_range(0, 3) == 0);
            run_cycle(s, 1'b0, nv);
        end

        // Saturation: preload the counter near the top, then keep missing.
        run_cycle(mks(0,0,0,0,0,0,0,0,0,0), 1'b0, nv);
        force dut.miss_count_q = 16'hFFFC;
        #1;
        release dut.miss_count_q;
        m_cnt = 'hFFFC;
        miss_s = mks(0,10'h000,1, 1,10'h100,4'd3,1,1,10'h200,0);
        for (int i = 0; i < 12; i++) begin
            run_cycle(miss_s, 1'b0, nv);
        end
        chk("count_saturated", {16'd0, miss_count}, 32'h0000FFFF);

        // Reset arriving mid-redirect, with the redirect stalled.
        run_cycle(miss_s, 1'b0, nv);
        run_cycle(mks(1,0,0,1,10'h100,4'd3,1,1,10'h200,1), 1'b0, nv);
        chk("rst_in_redirect", {31'd0, pc_redirect}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            run_cycle(mks(0,10'(i),1,0,0,0,0,0,0,0), 1'b0, nv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
